// File: rtl/sdram_write_pkg.sv
// sdram_write_pkg: widths, timings, command encodings and FSM states shared by the write path
package sdram_write_pkg;
  localparam int ADDR_BITS = 12;
  localparam int BA_BITS   = 2;
  localparam int DQ_BITS   = 16;
  localparam int ROW_BITS  = 12;
  localparam int COL_BITS  = 8;
  localparam int TMR_BITS  = 3;
  localparam int T_RCD     = 3;
  localparam int T_RP      = 3;
  localparam int T_WR      = 2;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  typedef enum logic [2:0] {WR_IDLE, WR_REQ, WR_ACT, WR_WRITE, WR_TWR, WR_PRE} wr_state_e;
endpackage

// File: rtl/sdram_write_if.sv
// sdram_write_if: arbiter, refresh, write-FIFO and SDRAM pin signals of the write engine
interface sdram_write_if;
  import sdram_write_pkg::*;
  logic                 wr_trig;
  logic                 aref_req;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DQ_BITS-1:0]   wfifo_data;
  logic                 wr_req;
  logic [3:0]           wr_cmd;
  logic [ADDR_BITS-1:0] addr_out;
  logic [BA_BITS-1:0]   ba_out;
  logic                 go_aref;
  logic                 wr_done_all;
  logic                 wfifo_rd_en;
  logic [DQ_BITS-1:0]   dq_out;
  logic                 dq_oe;
  modport master (
    input  wr_trig, aref_req, wr_en, wr_addr, wfifo_data,
    output wr_req, wr_cmd, addr_out, ba_out, go_aref, wr_done_all, wfifo_rd_en, dq_out, dq_oe
  );
  modport slave (
    output wr_trig, aref_req, wr_en, wr_addr, wfifo_data,
    input  wr_req, wr_cmd, addr_out, ba_out, go_aref, wr_done_all, wfifo_rd_en, dq_out, dq_oe
  );
endinterface

// File: rtl/sdram_phase_timer.sv
// sdram_phase_timer: counts while enabled, clears on exit, flags the programmed terminal count
module sdram_phase_timer #(
  parameter int W    = 3,
  parameter int TERM = 3
) (
  input  logic         sdram_clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign done_o = en_i && cnt_q == W'(TERM);
  assign cnt_d  = (en_i && !done_o) ? cnt_q + 1'b1 : '0;
  assign cnt_o  = cnt_q;
  // phase counter register
  always_ff @(posedge sdram_clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/sdram_write.sv
// sdram_write: SDRAM write-path engine, row-by-row BL4 bursts with refresh suspension
module sdram_write
  import sdram_write_pkg::*;
#(
  parameter int COL_ADDR_MAX = 3,
  parameter int ROW_MAX      = 0
) (
  input logic          sdram_clk,
  input logic          rst_n,
  sdram_write_if.master bus
);
  wr_state_e            state_q, state_d;
  logic [1:0]           burst_q, burst_d;
  logic [COL_BITS-3:0]  col_q, col_d;
  logic [ROW_BITS-1:0]  row_q, row_d, addr_row_q, addr_row_d;
  logic                 aref_q, aref_d, row_end_q, row_end_d, last_q, last_d, go_aref_q, go_aref_d;
  logic [TMR_BITS-1:0]  act_cnt, twr_cnt, pre_cnt;
  logic                 act_done, twr_done, pre_done, burst_done, col_done, twr_unused;
  logic [COL_BITS-1:0]  addr_col;

  sdram_phase_timer #(.W(TMR_BITS), .TERM(T_RCD)) u_act (
    .sdram_clk(sdram_clk), .rst_n(rst_n), .en_i(state_q == WR_ACT), .cnt_o(act_cnt), .done_o(act_done));
  sdram_phase_timer #(.W(TMR_BITS), .TERM(T_WR - 1)) u_twr (
    .sdram_clk(sdram_clk), .rst_n(rst_n), .en_i(state_q == WR_TWR), .cnt_o(twr_cnt), .done_o(twr_done));
  sdram_phase_timer #(.W(TMR_BITS), .TERM(T_RP)) u_pre (
    .sdram_clk(sdram_clk), .rst_n(rst_n), .en_i(state_q == WR_PRE), .cnt_o(pre_cnt), .done_o(pre_done));

  assign twr_unused = ^twr_cnt;
  assign addr_col   = {col_q, burst_q};
  assign burst_done = state_q == WR_WRITE && burst_q == 2'd3;
  assign col_done   = state_q == WR_WRITE && addr_col == COL_BITS'(COL_ADDR_MAX);

  // next state; a row end takes priority over a pending refresh at the same burst boundary
  always_comb begin
    state_d   = state_q;
    go_aref_d = 1'b0;
    case (state_q)
      WR_IDLE:  state_d = bus.wr_trig ? WR_REQ : WR_IDLE;
      WR_REQ:   state_d = bus.wr_en ? WR_ACT : WR_REQ;
      WR_ACT:   state_d = act_done ? WR_WRITE : WR_ACT;
      WR_WRITE: state_d = (col_done || (burst_done && aref_q)) ? WR_TWR : WR_WRITE;
      WR_TWR: if (twr_done) begin
        state_d   = row_end_q ? WR_PRE : WR_REQ;
        go_aref_d = !row_end_q;
      end
      WR_PRE: if (pre_done) begin
        state_d   = last_q ? WR_IDLE : aref_q ? WR_REQ : WR_ACT;
        go_aref_d = !last_q && aref_q;
      end
      default:  state_d = WR_IDLE;
    endcase
  end

  // counters and job flags; column position survives a refresh suspend
  always_comb begin
    burst_d    = state_q == WR_WRITE ? burst_q + 2'd1 : '0;
    col_d      = (state_q == WR_IDLE || col_done) ? '0 : burst_done ? col_q + 1'b1 : col_q;
    row_d      = state_q == WR_IDLE ? '0 : (state_q == WR_TWR && twr_done && row_end_q) ? row_q + 1'b1 : row_q;
    addr_row_d = state_q == WR_REQ ? bus.wr_addr : addr_row_q;
    aref_d     = state_q == WR_IDLE ? 1'b0 : bus.aref_req ? 1'b1 : act_done ? 1'b0 : aref_q;
    row_end_d  = (state_q == WR_WRITE && state_d == WR_TWR) ? col_done : row_end_q;
    last_d     = col_done ? row_q == ROW_BITS'(ROW_MAX) : state_q == WR_IDLE ? 1'b0 : last_q;
  end

  // state and datapath registers
  always_ff @(posedge sdram_clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= WR_IDLE;
      burst_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      addr_row_q <= '0;
      aref_q     <= 1'b0;
      row_end_q  <= 1'b0;
      last_q     <= 1'b0;
      go_aref_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_row_q <= addr_row_d;
      aref_q     <= aref_d;
      row_end_q  <= row_end_d;
      last_q     <= last_d;
      go_aref_q  <= go_aref_d;
    end

  assign bus.wr_req      = state_q == WR_REQ;
  assign bus.wr_cmd      = (state_q == WR_ACT && act_cnt == '0)   ? CMD_ACT :
                           (state_q == WR_WRITE && burst_q == '0) ? CMD_WRITE :
                           (state_q == WR_PRE && pre_cnt == '0)   ? CMD_PRE : CMD_NOP;
  assign bus.addr_out    = state_q == WR_ACT   ? addr_row_q + row_q :
                           state_q == WR_WRITE ? ADDR_BITS'(addr_col) :
                           state_q == WR_PRE   ? ADDR_BITS'(12'h400) : '0;
  assign bus.ba_out      = '0;
  assign bus.go_aref     = go_aref_q;
  assign bus.wr_done_all = pre_done && last_q;
  assign bus.wfifo_rd_en = act_done || (state_q == WR_WRITE && state_d == WR_WRITE);
  assign bus.dq_out      = bus.wfifo_data;
  assign bus.dq_oe       = state_q == WR_WRITE;
endmodule

// File: tb/tb_sdram_write.sv
// tb_sdram_write: random jobs against a phase-level timeline model of the write engine
module tb_sdram_write;
  import sdram_write_pkg::*;
  localparam int CMAX = 7;
  localparam int RMAX = 1;
  logic sdram_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 sdram_clk = ~sdram_clk;

  sdram_write_if bus();
  sdram_write #(.COL_ADDR_MAX(CMAX), .ROW_MAX(RMAX)) dut (.sdram_clk(sdram_clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [3:0]  e_cmd [256];
  logic [11:0] e_addr[256];
  logic [4:0]  e_flg [256];
  logic [15:0] e_dq  [256];
  bit          e_en  [256];
  logic [15:0] fifo  [64];
  int t_m, a_cyc;
  bit pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // one expected cycle; pend tracks the refresh flag as seen in the next cycle
  task automatic emit(input logic [3:0] c, input logic [11:0] ad, input logic [4:0] f,
                      input logic [15:0] d, input bit en, input bit act_last, input bit idle);
    e_cmd[t_m] = c; e_addr[t_m] = ad; e_flg[t_m] = f; e_dq[t_m] = d; e_en[t_m] = en;
    pend = idle ? 1'b0 : (t_m == a_cyc) ? 1'b1 : act_last ? 1'b0 : pend;
    t_m++;
  endtask

  // flags are {wr_req, dq_oe, wfifo_rd_en, go_aref, wr_done_all}
  task automatic build(input logic [11:0] addr, input int g1, input int g2, input int a, output int len);
    int row = 0, col = 0, beat = 0, g;
    bit need_req = 1, go_next = 0, first = 1, susp = 0, last, p = 0, row_end;
    t_m = 0; a_cyc = a; pend = 0;
    emit(CMD_NOP, 12'h0, 5'b0, 16'h0, 0, 0, 1);
    while (1) begin
      if (need_req) begin
        g = first ? g1 : g2;
        first = 0;
        for (int i = 0; i <= g; i++) emit(CMD_NOP, 12'h0, {1'b1, 2'b0, go_next && i == 0, 1'b0}, 16'h0, i == g, 0, 0);
        go_next = 0;
      end
      for (int i = 0; i < 4; i++) emit(i == 0 ? CMD_ACT : CMD_NOP, 12'(addr + row), {2'b0, i == 3, 2'b0}, 16'h0, 0, i == 3, 0);
      do begin
        row_end = col == CMAX;
        susp = col % 4 == 3 && !row_end && pend;
        emit(col % 4 == 0 ? CMD_WRITE : CMD_NOP, 12'(col), {2'b01, !(row_end || susp), 2'b0}, fifo[beat], 0, 0, 0);
        beat++;
        col = row_end ? 0 : col + 1;
      end while (!(row_end || susp));
      for (int i = 0; i < 2; i++) emit(CMD_NOP, 12'h0, 5'b0, 16'h0, 0, 0, 0);
      if (susp) begin
        need_req = 1;
        go_next = 1;
        continue;
      end
      last = row == RMAX;
      row++;
      for (int i = 0; i < 4; i++) begin
        p = pend;
        emit(i == 0 ? CMD_PRE : CMD_NOP, 12'h400, {4'b0, last && i == 3}, 16'h0, 0, 0, 0);
      end
      if (last) break;
      need_req = p;
      go_next = p;
    end
    emit(CMD_NOP, 12'h0, 5'b0, 16'h0, 0, 0, 1);
    emit(CMD_NOP, 12'h0, 5'b0, 16'h0, 0, 0, 1);
    len = t_m;
  endtask

  task automatic run_job(input logic [11:0] addr, input int g1, input int g2, input int a, input int abort);
    int len, pi = 0;
    bit rd;
    for (int k = 0; k < 64; k++) fifo[k] = 16'($urandom);
    build(addr, g1, g2, a, len);
    for (int t = 0; t < len; t++) begin
      bus.wr_trig = t == 0;
      bus.wr_en = e_en[t];
      bus.aref_req = t == a;
      bus.wr_addr = addr;
      if (t == abort) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_cmd", 32'(bus.wr_cmd), 32'(CMD_NOP));
        check("rst_oe", 32'(bus.dq_oe), 32'h0);
        check("rst_rd", 32'(bus.wfifo_rd_en), 32'h0);
        check("rst_req", 32'(bus.wr_req), 32'h0);
        bus.wr_trig = 1'b0; bus.wr_en = 1'b0; bus.aref_req = 1'b0;
        @(negedge sdram_clk);
        rst_n = 1'b1;
        @(posedge sdram_clk);
        #1;
        return;
      end
      @(negedge sdram_clk);
      check("cmd", 32'(bus.wr_cmd), 32'(e_cmd[t]));
      check("addr", 32'(bus.addr_out), 32'(e_addr[t]));
      check("flags", 32'({bus.wr_req, bus.dq_oe, bus.wfifo_rd_en, bus.go_aref, bus.wr_done_all}), 32'(e_flg[t]));
      if (e_flg[t][3]) check("dq", 32'(bus.dq_out), 32'(e_dq[t]));
      if (t == 0) check("ba", 32'(bus.ba_out), 32'h0);
      rd = bus.wfifo_rd_en;
      @(posedge sdram_clk);
      #1;
      if (rd && pi < 64) begin
        bus.wfifo_data = fifo[pi];
        pi++;
      end
    end
    bus.wr_trig = 1'b0; bus.wr_en = 1'b0; bus.aref_req = 1'b0;
  endtask

  initial begin
    bus.wr_trig = 1'b0; bus.wr_en = 1'b0; bus.aref_req = 1'b0;
    bus.wr_addr = '0; bus.wfifo_data = '0;
    #2;
    check("reset_cmd", 32'(bus.wr_cmd), 32'(CMD_NOP));
    check("reset_addr", 32'(bus.addr_out), 32'h0);
    check("reset_flags", 32'({bus.wr_req, bus.dq_oe, bus.wfifo_rd_en, bus.go_aref, bus.wr_done_all}), 32'h0);
    @(negedge sdram_clk);
    rst_n = 1'b1;
    @(posedge sdram_clk);
    #1;
    run_job(12'h005, 2, 1, -1, -1);
    run_job(12'h0A0, 2, 1, 9, -1);
    run_job(12'h010, 2, 3, 14, -1);
    run_job(12'h020, 2, 0, 32, -1);
    run_job(12'h030, 2, 0, 33, -1);
    run_job(12'hFFF, 0, 0, -1, -1);
    run_job(12'h007, 2, 1, -1, 11);
    run_job(12'h007, 1, 1, -1, -1);
    repeat (40) begin
      int a;
      a = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 60));
      run_job(($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), a, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 30)) : -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
